winograd_tile_buffer: RTL
=========================

# winograd_tile_buffer

Streaming line-buffer and window extractor that turns a raster-order pixel stream into overlapping TILE×TILE input tiles for the Winograd transform stage. For the default F(2×2,3×3) configuration these are 4×4 tiles at stride 2. It sits between the pixel source and the input-transform/MAC array. It replaces the fixed 4-row column output with a fully parametrised tile emitter that supports image size, tile size, stride, ready/valid backpressure, tile coordinates and frame-boundary signalling.

## Interface
- DATA_W, 8: pixel width in bits
- IMG_W, 640: pixels per row; must be ≥ TILE
- IMG_H, 360: rows per frame; must be ≥ TILE
- TILE, 4: tile edge; 4 or 6
- STRIDE, 2: tile step in both dimensions; 1 ≤ STRIDE ≤ TILE

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low reset
- io_in_valid  in  1  pixel valid
- io_in_ready  out  1  block accepts a pixel
- io_in_data  in  DATA_W  pixel, raster order, row-major
- io_tile_valid  out  1  tile valid
- io_tile_ready  in  1  downstream accepts tile
- io_tile  out  TILE*TILE*DATA_W  element (i,j) at bits [(i*TILE+j)*DATA_W +: DATA_W]; i=0 is the top (oldest) row and j=0 the leftmost column
- io_tile_row  out  $clog2(IMG_H)  tile row index
- io_tile_col  out  $clog2(IMG_W)  tile column index
- io_frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted

## Operation
- Handshake. A pixel is accepted when io_in_valid && io_in_ready. io_in_ready = !io_tile_valid || io_tile_ready, so a single output register is used and no pixel is dropped.
- Position counters. Column counter c counts 0..IMG_W-1 and row counter r counts 0..IMG_H-1. Both advance only on acceptance. c wraps to 0 and increments r. At (IMG_H-1, IMG_W-1) both wrap to 0 and io_frame_done pulses.
- Line buffers. There are TILE-1 row buffers, each IMG_W deep, arranged as a chain: row k's output feeds row k+1's input at column c. On acceptance, the column vector {lb[TILE-2]..lb[0] at c, io_in_data} shifts into a TILE×TILE window register, with the new column entering at j=TILE-1.
- Tile emission. On acceptance of pixel (r,c), a tile is emitted when all of the following hold:
  - r ≥ TILE-1 and c ≥ TILE-1
  - (r-TILE+1) % STRIDE == 0
  - (c-TILE+1) % STRIDE == 0
- Emission actions. The emitting acceptance loads io_tile from the updated window, sets io_tile_row=(r-TILE+1)/STRIDE and io_tile_col=(c-TILE+1)/STRIDE, and sets io_tile_valid.
- Modulo and divide. Use per-dimension phase counters that wrap at STRIDE and tile-index counters. No dividers.
- Tile count. Each frame yields ((IMG_H-TILE)/STRIDE+1)·((IMG_W-TILE)/STRIDE+1) tiles. Trailing pixels that complete no full stride step produce no tile.
- Frame isolation. The r/c conditions guarantee that no window mixes rows across a row wrap or data across frames. Stale line-buffer contents are never emitted.
- Holding. io_tile_valid clears on io_tile_ready when no new tile is loaded in the same cycle. If a new tile is loaded in the same cycle the old one is accepted, valid stays 1 and the payload updates.

## Timing
- Reset values (asynchronous, immediate when reset=0):
  - io_tile_valid=0, io_tile=0, io_tile_row=0, io_tile_col=0, io_frame_done=0
  - counters=0, io_in_ready=1
  - line-buffer and window contents undefined
- Latency: a tile is presented the cycle after the accepting edge of its completing pixel.
- Stability: while io_tile_valid && !io_tile_ready, io_tile, io_tile_row and io_tile_col hold stable, and io_in_ready=0.
- Throughput: one pixel per cycle when downstream is always ready.
- io_frame_done: asserted the cycle after the last pixel is accepted, for exactly one cycle. It is independent of tile backpressure.
- Back-to-back frames: pixel (0,0) of the next frame may be accepted the cycle after the last pixel of the previous frame.
- Reset mid-frame: the outstanding tile is discarded and the next accepted pixel is treated as (0,0).

## Test plan
Config for all scenarios: IMG_W=8, IMG_H=6, TILE=4, STRIDE=2, DATA_W=8. The pixel at (r,c) has value r·8+c.

- Continuous stream, ready held high:
  - First tile appears one cycle after pixel (3,3) is accepted, with row=0, col=0 and element (i,j)=8i+j.
  - Next tile appears after pixel (3,5), with col=1 and element (i,j)=8i+j+2.
  - Exactly 6 tiles per frame.
- io_tile_ready low for 5 cycles while a tile is valid:
  - io_in_ready=0 for those cycles.
  - Tile payload and indices are unchanged.
  - No pixel is lost and the tile sequence matches the unstalled run.
- Frame boundary:
  - io_frame_done pulses once, the cycle after the 48th acceptance.
  - A second back-to-back frame with the same stimulus yields 6 identical tiles with row/col restarting at 0.
- io_in_valid toggled randomly, 50% duty: same 6 tiles, in the same order, with the same indices.
- Reset asserted after 20 pixels, then a full frame is sent:
  - Outputs read their reset values immediately during reset.
  - After release, the full frame yields exactly the 6 reference tiles.
- STRIDE=1 rerun: 15 tiles per frame (3×5); the tile with row=2, col=4 has element (0,0)=20.

Source files
------------

// File: rtl/winograd_tile_buffer.sv
// Streaming line buffer and window extractor: turns a raster pixel stream into
// overlapping TILE x TILE tiles stepped by STRIDE, with ready/valid on both sides.
module winograd_tile_buffer #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 360,
  parameter int TILE   = 4,
  parameter int STRIDE = 2
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          io_in_valid,
  output logic                          io_in_ready,
  input  logic [DATA_W-1:0]             io_in_data,
  output logic                          io_tile_valid,
  input  logic                          io_tile_ready,
  output logic [TILE*TILE*DATA_W-1:0]   io_tile,
  output logic [$clog2(IMG_H)-1:0]      io_tile_row,
  output logic [$clog2(IMG_W)-1:0]      io_tile_col,
  output logic                          io_frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int PW = $clog2(STRIDE + 1);

  typedef logic [TILE-1:0][TILE-1:0][DATA_W-1:0] window_t;

  logic [CW-1:0]     col_cnt;
  logic [CW-1:0]     tile_col_idx;
  logic [RW-1:0]     row_cnt;
  logic [RW-1:0]     tile_row_idx;
  logic [PW-1:0]     col_phase;
  logic [PW-1:0]     row_phase;
  logic              accept;
  logic              col_last;
  logic              row_last;
  logic              col_live;
  logic              row_live;
  logic              emit;
  logic [DATA_W-1:0] lb [TILE-1][IMG_W];
  window_t           window;
  window_t           window_next;
  logic [TILE-1:0][DATA_W-1:0] column;

  assign io_in_ready = !io_tile_valid || io_tile_ready;
  assign accept      = io_in_valid && io_in_ready;
  assign col_last    = col_cnt == CW'(IMG_W - 1);
  assign row_last    = row_cnt == RW'(IMG_H - 1);
  assign col_live    = col_cnt >= CW'(TILE - 1);
  assign row_live    = row_cnt >= RW'(TILE - 1);
  assign emit        = accept && col_live && row_live &&
                       col_phase == '0 && row_phase == '0;

  // Row i of the window comes from the buffer holding the row TILE-1-i lines back.
  always_comb begin
    column      = '0;
    window_next = window;
    column[TILE-1] = io_in_data;
    for (int i = 0; i < TILE - 1; i++) column[i] = lb[TILE-2-i][col_cnt];
    for (int i = 0; i < TILE; i++) begin
      for (int j = 0; j < TILE - 1; j++) window_next[i][j] = window[i][j+1];
      window_next[i][TILE-1] = column[i];
    end
  end

  always_ff @(posedge clock) begin
    if (accept) begin
      lb[0][col_cnt] <= io_in_data;
      for (int k = 1; k < TILE - 1; k++) lb[k][col_cnt] <= lb[k-1][col_cnt];
      window <= window_next;
    end
  end

  // Phases only start stepping once a full tile edge has been seen in that dimension.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      col_cnt      <= '0;
      row_cnt      <= '0;
      col_phase    <= '0;
      row_phase    <= '0;
      tile_col_idx <= '0;
      tile_row_idx <= '0;
    end else if (accept) begin
      if (col_last) begin
        col_cnt      <= '0;
        col_phase    <= '0;
        tile_col_idx <= '0;
        if (row_last) begin
          row_cnt      <= '0;
          row_phase    <= '0;
          tile_row_idx <= '0;
        end else begin
          row_cnt <= row_cnt + 1'b1;
          if (row_live) begin
            if (row_phase == PW'(STRIDE - 1)) begin
              row_phase    <= '0;
              tile_row_idx <= tile_row_idx + 1'b1;
            end else begin
              row_phase <= row_phase + 1'b1;
            end
          end
        end
      end else begin
        col_cnt <= col_cnt + 1'b1;
        if (col_live) begin
          if (col_phase == PW'(STRIDE - 1)) begin
            col_phase    <= '0;
            tile_col_idx <= tile_col_idx + 1'b1;
          end else begin
            col_phase <= col_phase + 1'b1;
          end
        end
      end
    end
  end

  // A newly emitted tile replaces the held one in the same cycle it is taken.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      io_tile_valid <= 1'b0;
      io_tile       <= '0;
      io_tile_row   <= '0;
      io_tile_col   <= '0;
      io_frame_done <= 1'b0;
    end else begin
      io_frame_done <= accept && col_last && row_last;
      if (emit) begin
        io_tile_valid <= 1'b1;
        io_tile       <= window_next;
        io_tile_row   <= tile_row_idx;
        io_tile_col   <= tile_col_idx;
      end else if (io_tile_ready) begin
        io_tile_valid <= 1'b0;
      end
    end
  end

endmodule
